// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl -- sequencing controller for the iterative multiply/divide unit.
//
// A start pulse from the execute stage loads the operands, iterates the
// datapath for the selected operation, runs a sign/remainder fix-up cycle
// for divide, and then returns a one-cycle result-ready pulse.
//
// Ports
//   clock, reset          system clock (rising edge), synchronous active-high reset
//   ctrl_MULT, ctrl_DIV   start pulses; multiply wins when both are high
//   divisor_zero          datapath flag, looked at in the LOAD cycle of a divide
//   early_done            datapath flag: remaining multiplier bits are zero
//   load, step_en, fix_en datapath strobes (mutually exclusive)
//   is_div                operation select latched on each accepted start
//   step_count            current iteration index
//   busy                  high in LOAD, RUN and FIX
//   data_resultRDY        one-cycle result-valid pulse
//   data_exception        divide-by-zero flag, qualified by data_resultRDY
//
// Build option
//   MULTDIV_EARLY_TERM_EN  when defined, early_done ends a multiply RUN after
//                          the current step. Otherwise early_done is ignored.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a start pulse
// LOAD  | operands loaded, step counter cleared, divisor checked
// RUN   | one datapath iteration per cycle, step_count = 0..N-1
// FIX   | divide sign/remainder correction
// DONE  | result-ready pulse, exception flag presented

module multdiv_ctrl #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             early_done,
  output logic             load,
  output logic             step_en,
  output logic             fix_en,
  output logic             is_div,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             exc_q, exc_d;
  logic             start;
  logic             run_last;
  logic             early_term;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign run_last = (cnt_q == (is_div_q ? DIV_LAST : MULT_LAST));

`ifdef MULTDIV_EARLY_TERM_EN
  // Only meaningful for multiply; a divide always runs all its steps.
  assign early_term = ~is_div_q & early_done;
`else
  logic unused_early_done;
  assign unused_early_done = early_done;
  assign early_term        = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start in any state (re)enters LOAD; in DONE the
  // Moore output still delivers that cycle's ready pulse first.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: state_d = (is_div_q && divisor_zero) ? S_DONE : S_RUN;
        S_RUN: begin
          if (run_last) begin
            state_d = is_div_q ? S_FIX : S_DONE;
          end else if (early_term) begin
            state_d = S_DONE;
          end
        end
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic (Moore)
  always_comb begin
    load           = 1'b0;
    step_en        = 1'b0;
    fix_en         = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    case (state_q)
      S_LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_RUN: begin
        step_en = 1'b1;
        busy    = 1'b1;
      end
      S_FIX: begin
        fix_en = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        data_resultRDY = 1'b1;
        data_exception = exc_q;
      end
      default: ;
    endcase
  end

  // Step counter, operation select and exception flag
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    exc_d    = exc_q;
    if (start) begin
      cnt_d    = '0;
      is_div_d = ctrl_DIV & ~ctrl_MULT;
      exc_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: exc_d = is_div_q & divisor_zero;
        S_RUN: begin
          // Counter stops on the final (or early-terminated) step, so it
          // never wraps and holds its last index through FIX/DONE.
          if (!run_last && !early_term) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
    end
  end

  assign step_count = cnt_q;
  assign is_div     = is_div_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

  localparam int MS    = 16;
  localparam int DS    = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ctrl_MULT = 1'b0;
  logic             ctrl_DIV = 1'b0;
  logic             divisor_zero = 1'b0;
  logic             early_done = 1'b0;
  logic             load, step_en, fix_en, is_div, busy;
  logic             data_resultRDY, data_exception;
  logic [CNT_W-1:0] step_count;

  multdiv_ctrl #(.MULT_STEPS(MS), .DIV_STEPS(DS), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .divisor_zero   (divisor_zero),
    .early_done     (early_done),
    .load           (load),
    .step_en        (step_en),
    .fix_en         (fix_en),
    .is_div         (is_div),
    .step_count     (step_count),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int   at;
    logic d;
    logic e;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic expect_rdy(input int at, input logic d, input logic e);
    exp_t x;
    x.at = at;
    x.d  = d;
    x.e  = e;
    sbq.push_back(x);
  endtask

  // Monitor: pops the scoreboard on every ready pulse.
  always @(negedge clock) begin
    if (mon_en) begin
      check("strobe_excl", int'($countones({load, step_en, fix_en, data_resultRDY}) <= 1), 1);
      if (!data_resultRDY) begin
        check("exc_unqualified", int'(data_exception), 0);
      end else if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy @cyc %0d: got rdy=1 want rdy=0", cyc);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        check("rdy_cycle", cyc, x.at);
        check("rdy_is_div", int'(is_div), int'(x.d));
        check("rdy_exception", int'(data_exception), int'(x.e));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a start pulse during the current cycle; returns one cycle later
  // (in the LOAD cycle) with the start lines released.
  task automatic issue(input logic m, input logic d);
    ctrl_MULT = m;
    ctrl_DIV  = d;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Walk cycles 1..done of an operation started in cycle c0, checking strobes.
  task automatic follow(input int c0, input int nrun, input bit fix, input bit zero, input logic d);
    int done_k;
    done_k = zero ? 2 : (2 + nrun + (fix ? 1 : 0));
    for (int k = 1; k <= done_k; k++) begin
      int exp_cnt;
      @(negedge clock);
      if (k <= 1 || zero)   exp_cnt = 0;
      else if (k < 2 + nrun) exp_cnt = k - 2;
      else                   exp_cnt = nrun - 1;
      check("cycle_index", cyc - c0, k);
      check("load", int'(load), int'(k == 1));
      check("step_en", int'(step_en), int'(!zero && k >= 2 && k < 2 + nrun));
      check("fix_en", int'(fix_en), int'(fix && !zero && k == 2 + nrun));
      check("busy", int'(busy), int'(k < done_k));
      check("step_count", int'(step_count), exp_cnt);
      check("is_div", int'(is_div), int'(d));
    end
  endtask

  initial begin
    int c0;
    int c1;
    repeat (3) tick();
    @(negedge clock);
    check("rst_load", int'(load), 0);
    check("rst_step_en", int'(step_en), 0);
    check("rst_fix_en", int'(fix_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rdy", int'(data_resultRDY), 0);
    check("rst_exc", int'(data_exception), 0);
    check("rst_step_count", int'(step_count), 0);
    check("rst_is_div", int'(is_div), 0);
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Multiply: load cycle 1, steps 2..17, ready cycle 18
    c0 = cyc;
    expect_rdy(c0 + MS + 2, 1'b0, 1'b0);
    issue(1'b1, 1'b0);
    follow(c0, MS, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Divide: steps 2..33, fix 34, ready 35
    c0 = cyc;
    expect_rdy(c0 + DS + 3, 1'b1, 1'b0);
    issue(1'b0, 1'b1);
    follow(c0, DS, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();

    // Divide by zero, then a multiply started in the DONE cycle
    c0 = cyc;
    expect_rdy(c0 + 2, 1'b1, 1'b1);
    divisor_zero = 1'b1;
    issue(1'b0, 1'b1);
    follow(c0, DS, 1'b1, 1'b1, 1'b1);
    divisor_zero = 1'b0;
    c1 = cyc;
    check("restart_in_done", c1 - c0, 2);
    expect_rdy(c1 + MS + 2, 1'b0, 1'b0);
    issue(1'b1, 1'b0);
    follow(c1, MS, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Both starts together: multiply wins
    c0 = cyc;
    expect_rdy(c0 + MS + 2, 1'b0, 1'b0);
    issue(1'b1, 1'b1);
    follow(c0, MS, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Multiply aborted by a divide at cycle 10; only the divide completes
    c0 = cyc;
    issue(1'b1, 1'b0);
    repeat (9) tick();
    c1 = cyc;
    check("abort_start_cycle", c1 - c0, 10);
    expect_rdy(c1 + DS + 3, 1'b1, 1'b0);
    issue(1'b0, 1'b1);
    follow(c1, DS, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();

    // Reset during cycle 8 of a multiply; no ready pulse afterwards
    c0 = cyc;
    issue(1'b1, 1'b0);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rstmid_cycle", cyc - c0, 9);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_step_en", int'(step_en), 0);
    check("rstmid_step_count", int'(step_count), 0);
    repeat (25) tick();

    // early_done raised on step 3 of a multiply
    c0 = cyc;
`ifdef MULTDIV_EARLY_TERM_EN
    // RUN exits after the step on which early_done is seen (step 3 = cycle 5)
    expect_rdy(c0 + 6, 1'b0, 1'b0);
`else
    expect_rdy(c0 + MS + 2, 1'b0, 1'b0);
`endif
    issue(1'b1, 1'b0);
    for (int i = 0; i < 10 && !(step_en && step_count == 3); i++) @(negedge clock);
    check("early_step3_seen", int'(step_en && step_count == 3), 1);
    early_done = 1'b1;
    tick();
    early_done = 1'b0;
    repeat (20) tick();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
    check("missing_rdy", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
